// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin slot arbiter and its
// combinational pick stage.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N_DEF        = 5;
  localparam int ARB_MAX_HOLD_DEF = 16;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest requester at or above ptr,
// otherwise the lowest requester overall.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = ARB_N_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] winner_idx,
  output logic [N-1:0]  winner_onehot
);

  logic [N-1:0] mask;
  logic [N-1:0] masked_req;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi] = (IW'(gi) >= ptr);
    end
  endgenerate

  assign masked_req = req & mask;

  // Scans run high-to-low so the last hit is the lowest index; the masked
  // scan runs second and overrides the unmasked fallback when it hits.
  always_comb begin
    found         = |req;
    winner_idx    = '0;
    winner_onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner_idx = IW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (masked_req[i]) begin
        winner_idx = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      winner_onehot[i] = found && (winner_idx == IW'(i));
    end
  end

endmodule

// File: rtl/rr_slot_arbiter.sv
// Round-robin arbiter owning one shared write port; the grant is held until
// released. Define ARB_TIMEOUT_EN to add a forced release after MAX_HOLD cycles.
module rr_slot_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEF,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 timeout
);

  localparam int IW = idx_w(N);

  if (N < 2 || N > 32 || MAX_HOLD < 2) begin : g_param_check
    $error("rr_slot_arbiter: N must be 2..32 and MAX_HOLD >= 2");
  end

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;

  logic          found;
  logic [IW-1:0] winner_idx;
  logic [N-1:0]  winner_onehot;
  logic          normal_rel;
  logic          forced;
  logic          take;
  logic          hold_limit;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req           (req),
    .ptr           (ptr_q),
    .found         (found),
    .winner_idx    (winner_idx),
    .winner_onehot (winner_onehot)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    normal_rel  = done || !req[grant_idx_q];
    forced      = 1'b0;
    take        = 1'b0;
    case (state_q)
      IDLE: begin
        take = found;
      end
      GRANT: begin
        forced = hold_limit && !normal_rel;
        if (normal_rel || forced) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d     = IDLE;
            grant_d     = '0;
            grant_idx_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The pointer lands one past the winner so the owner goes to the back.
    if (take) begin
      state_d     = GRANT;
      grant_d     = winner_onehot;
      grant_idx_d = winner_idx;
      ptr_d       = (winner_idx == IW'(N - 1)) ? '0 : winner_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HW = idx_w(MAX_HOLD);

  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;

  assign hold_limit = (hold_q == HW'(MAX_HOLD - 1));

  // Any new grant, including a regrant of the same owner, restarts the count.
  always_comb begin
    hold_d    = '0;
    timeout_d = forced;
    if (!take && state_q == GRANT) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_limit = 1'b0;
  assign timeout    = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// Self-checking bench for rr_slot_arbiter: a circular-scan reference model
// feeds a scoreboard, plus directed scenario checks against fixed values.
module tb_rr_slot_arbiter;

  localparam int N        = 5;
  localparam int IW       = 3;
  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          done = 1'b0;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          timeout;

  rr_slot_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  g;
    logic [IW-1:0] idx;
    logic          to;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   txn    = 0;

  bit m_valid = 1'b0;
  int m_ptr   = 0;
  int m_idx   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  function automatic int m_pick(input logic [N-1:0] r, input int p);
    int i;
    for (int k = 0; k < N; k++) begin
      i = (p + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // One clock of stimulus; the model predicts the outputs after the edge.
  task automatic drive(input logic [N-1:0] r, input logic d, input logic rs);
    int   w;
    bit   rel_norm;
    bit   frc;
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    rst  = rs;
    m_to = 1'b0;
    if (rs) begin
      m_valid = 1'b0; m_ptr = 0; m_idx = 0; m_hold = 0;
    end else if (!m_valid) begin
      w = m_pick(r, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1; m_idx = w; m_ptr = (w + 1) % N; m_hold = 0;
      end
    end else begin
      rel_norm = d || !r[m_idx];
      frc      = TO_EN && (m_hold == MAX_HOLD - 1) && !rel_norm;
      if (rel_norm || frc) begin
        w = m_pick(r, m_ptr);
        if (w >= 0) begin
          m_idx = w; m_ptr = (w + 1) % N;
        end else begin
          m_valid = 1'b0; m_idx = 0;
        end
        m_hold = 0;
        m_to   = frc;
      end else begin
        m_hold++;
      end
    end
    e.g   = m_valid ? (N'(1) << m_idx) : '0;
    e.idx = IW'(m_idx);
    e.to  = m_to;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      txn++;
      $display("txn %0d req=%b done=%b rst=%b grant=%b idx=%0d valid=%b timeout=%b",
               txn, req, done, rst, grant, grant_idx, grant_valid, timeout);
      checks++;
      if (grant !== mon_e.g) $display("FAIL sb_grant txn=%0d actual=%b required=%b", txn, grant, mon_e.g);
      else passes++;
      checks++;
      if (grant_idx !== mon_e.idx) $display("FAIL sb_idx txn=%0d actual=%0d required=%0d", txn, grant_idx, mon_e.idx);
      else passes++;
      checks++;
      if (grant_valid !== (mon_e.g != '0)) $display("FAIL sb_valid txn=%0d actual=%b required=%b", txn, grant_valid, mon_e.g != '0);
      else passes++;
      checks++;
      if (timeout !== mon_e.to) $display("FAIL sb_timeout txn=%0d actual=%b required=%b", txn, timeout, mon_e.to);
      else passes++;
    end
  end

  task automatic test_reset();
    drive('0, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b1);
    checks++;
    if (grant !== 5'b00000 || grant_valid !== 1'b0 || grant_idx !== 3'd0 || timeout !== 1'b0)
      $display("FAIL reset_state actual=%b/%b/%0d/%b required=00000/0/0/0", grant, grant_valid, grant_idx, timeout);
    else passes++;
  endtask

  task automatic test_basic();
    drive(5'b10100, 1'b0, 1'b0);
    checks++;
    if (grant !== 5'b00100 || grant_idx !== 3'd2) $display("FAIL basic_first actual=%b/%0d required=00100/2", grant, grant_idx);
    else passes++;
    drive(5'b10100, 1'b1, 1'b0);
    checks++;
    if (grant !== 5'b10000 || grant_idx !== 3'd4) $display("FAIL basic_second actual=%b/%0d required=10000/4", grant, grant_idx);
    else passes++;
    drive(5'b10100, 1'b1, 1'b0);
    checks++;
    if (grant_idx !== 3'd2) $display("FAIL basic_wrap actual=%0d required=2", grant_idx);
    else passes++;
    drive(5'b00000, 1'b0, 1'b0);
    checks++;
    if (grant !== 5'b00000 || grant_valid !== 1'b0) $display("FAIL basic_idle actual=%b/%b required=00000/0", grant, grant_valid);
    else passes++;
  endtask

  task automatic test_rotate();
    int seq[6] = '{0, 1, 2, 3, 4, 0};
    drive('0, 1'b0, 1'b1);
    drive(5'b11111, 1'b0, 1'b0);
    checks++;
    if (grant_idx !== 3'(seq[0]) || grant_valid !== 1'b1) $display("FAIL rotate_0 actual=%0d required=%0d", grant_idx, seq[0]);
    else passes++;
    for (int k = 1; k < 6; k++) begin
      drive(5'b11111, 1'b1, 1'b0);
      checks++;
      if (grant_idx !== 3'(seq[k]) || grant_valid !== 1'b1) $display("FAIL rotate_%0d actual=%0d required=%0d", k, grant_idx, seq[k]);
      else passes++;
    end
  endtask

  task automatic test_single();
    drive('0, 1'b0, 1'b1);
    drive(5'b01000, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(5'b01000, (k % 2) == 1, 1'b0);
      checks++;
      if (grant_idx !== 3'd3 || grant !== 5'b01000) $display("FAIL single_%0d actual=%b/%0d required=01000/3", k, grant, grant_idx);
      else passes++;
    end
  endtask

  task automatic test_owner_drop();
    drive('0, 1'b0, 1'b1);
    drive(5'b00010, 1'b0, 1'b0);
    checks++;
    if (grant_idx !== 3'd1) $display("FAIL drop_grant actual=%0d required=1", grant_idx);
    else passes++;
    drive(5'b00000, 1'b0, 1'b0);
    checks++;
    if (grant !== 5'b00000 || grant_valid !== 1'b0) $display("FAIL drop_release actual=%b/%b required=00000/0", grant, grant_valid);
    else passes++;
    drive(5'b00000, 1'b1, 1'b0);
    checks++;
    if (grant_valid !== 1'b0) $display("FAIL done_idle actual=%b required=0", grant_valid);
    else passes++;
  endtask

  task automatic test_reset_mid();
    drive('0, 1'b0, 1'b1);
    drive(5'b00100, 1'b0, 1'b0);
    drive(5'b00100, 1'b1, 1'b1);
    checks++;
    if (grant !== 5'b00000 || grant_valid !== 1'b0) $display("FAIL rstmid_drop actual=%b/%b required=00000/0", grant, grant_valid);
    else passes++;
    drive(5'b00110, 1'b0, 1'b0);
    checks++;
    if (grant_idx !== 3'd1 || grant !== 5'b00010) $display("FAIL rstmid_regrant actual=%b/%0d required=00010/1", grant, grant_idx);
    else passes++;
  endtask

  task automatic test_timeout();
    drive('0, 1'b0, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      drive(5'b00011, 1'b0, 1'b0);
      checks++;
      if (grant_idx !== 3'd0 || timeout !== 1'b0) $display("FAIL to_hold_%0d actual=%0d/%b required=0/0", k, grant_idx, timeout);
      else passes++;
    end
    drive(5'b00011, 1'b0, 1'b0);
    checks++;
    if (grant_idx !== 3'd1 || timeout !== 1'b1) $display("FAIL to_force actual=%0d/%b required=1/1", grant_idx, timeout);
    else passes++;
    drive(5'b00011, 1'b0, 1'b0);
    checks++;
    if (timeout !== 1'b0) $display("FAIL to_pulse actual=%b required=0", timeout);
    else passes++;
    drive('0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) drive(5'b00011, 1'b0, 1'b0);
    drive(5'b00011, 1'b1, 1'b0);
    checks++;
    if (grant_idx !== 3'd1 || timeout !== 1'b0) $display("FAIL to_done_limit actual=%0d/%b required=1/0", grant_idx, timeout);
    else passes++;
`else
    for (int k = 0; k < 120; k++) begin
      drive(5'b00011, 1'b0, 1'b0);
      checks++;
      if (grant_idx !== 3'd0 || timeout !== 1'b0) $display("FAIL hold_%0d actual=%0d/%b required=0/0", k, grant_idx, timeout);
      else passes++;
    end
`endif
  endtask

  task automatic test_random();
    drive('0, 1'b0, 1'b1);
    for (int k = 0; k < 300; k++) begin
      drive(N'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotate();
    test_single();
    test_owner_drop();
    test_reset_mid();
    test_timeout();
    test_random();
    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
